// File: rtl/tb_seq_pkg.sv
// Shared encodings for the test sequencer: one-hot FSM states and the
// "delay not yet measured" sentinel.
package tb_seq_pkg;

    localparam int IDX_IDLE  = 0;
    localparam int IDX_CALIB = 1;
    localparam int IDX_RUN   = 2;
    localparam int IDX_DONE  = 3;
    localparam int IDX_ERROR = 4;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_CALIB = 5'b00010;
    localparam logic [4:0] ST_RUN   = 5'b00100;
    localparam logic [4:0] ST_DONE  = 5'b01000;
    localparam logic [4:0] ST_ERROR = 5'b10000;

    localparam logic [31:0] DELAY_UNKNOWN = 32'hFFFF_FFFF;

endpackage

// File: rtl/test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_dut,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // count register: reset, then clear, then saturating increment
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/test_sequencer.sv
// Test-run sequencer: waits for the DUT latency to be measured, skips the
// pipeline fill, then tallies monitor results and captures the first failure.
module test_sequencer
    import tb_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1024,
    parameter int FILL_EXTRA = 3
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_manual,
    input  logic [CNT_W-1:0] i_num_tests,
    input  logic [31:0]      i_dut_delay,
    input  logic             i_mon_valid,
    input  logic             i_mon_match,
    input  logic [WIDTH-1:0] i_mon_a,
    input  logic [WIDTH-1:0] i_mon_b,
    output logic             o_fselect,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_fail_count,
    output logic             o_fail_seen,
    output logic [WIDTH-1:0] o_first_fail_a,
    output logic [WIDTH-1:0] o_first_fail_b
);

    localparam int          FILL_W       = 18;
    localparam logic [31:0] CALIB_LAST   = 32'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_ADD = FILL_W'(FILL_EXTRA);

    logic [4:0]        r_state;
    logic [4:0]        w_next_state;
    logic [CNT_W-1:0]  r_num_tests;
    logic [31:0]       r_calib_cnt;
    logic [FILL_W-1:0] r_fill;
    logic              r_fail_seen;
    logic [WIDTH-1:0]  r_first_a;
    logic [WIDTH-1:0]  r_first_b;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic              w_start_ok;
    logic              w_start_acc;
    logic              w_delay_known;
    logic              w_take;
    logic              w_pass_inc;
    logic              w_fail_inc;
    logic [CNT_W-1:0]  w_pass_cnt;
    logic [CNT_W-1:0]  w_fail_cnt;
    logic [CNT_W:0]    w_sum;
    logic [CNT_W:0]    w_sum_next;
    logic              w_enough;
    logic              w_done_now;

    assign w_start_ok    = i_start & (r_state[IDX_IDLE] | r_state[IDX_DONE] | r_state[IDX_ERROR]);
    assign w_start_acc   = w_start_ok & ~i_abort;
    assign w_delay_known = (i_dut_delay != DELAY_UNKNOWN);

    // Sum is one bit wider than the counters so pass+fail never wraps
    assign w_sum      = {1'b0, w_pass_cnt} + {1'b0, w_fail_cnt};
    assign w_enough   = (w_sum >= {1'b0, r_num_tests});
    assign w_take     = r_state[IDX_RUN] & (r_fill == '0) & i_mon_valid & ~w_enough & ~i_abort;
    assign w_pass_inc = w_take & i_mon_match;
    assign w_fail_inc = w_take & ~i_mon_match;
    assign w_sum_next = w_sum + {{CNT_W{1'b0}}, w_take};
    assign w_done_now = (w_sum_next >= {1'b0, r_num_tests});

    // next-state decode; abort outranks start, start outranks completion
    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else if (w_start_ok) begin
            w_next_state = ST_CALIB;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_IDLE;
                ST_CALIB: begin
                    if (w_delay_known) begin
                        w_next_state = (r_num_tests == '0) ? ST_DONE : ST_RUN;
                    end else if (r_calib_cnt == CALIB_LAST) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_next_state = ST_CALIB;
                    end
                end
                ST_RUN:   w_next_state = w_done_now ? ST_DONE : ST_RUN;
                ST_DONE:  w_next_state = ST_DONE;
                ST_ERROR: w_next_state = ST_ERROR;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // state register and flags decoded from the state being entered
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= w_next_state[IDX_CALIB] | w_next_state[IDX_RUN];
            r_done    <= w_next_state[IDX_DONE];
            r_timeout <= w_next_state[IDX_ERROR];
        end
    end

    // run setup: latched test count, calibration timer, fill down-counter
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            r_num_tests <= '0;
            r_calib_cnt <= 32'd0;
            r_fill      <= '0;
        end else begin
            if (w_start_acc) begin
                r_num_tests <= i_num_tests;
                r_calib_cnt <= 32'd0;
            end else if (r_state[IDX_CALIB]) begin
                r_calib_cnt <= r_calib_cnt + 32'd1;
            end else begin
                r_calib_cnt <= r_calib_cnt;
            end

            if (r_state[IDX_CALIB] && w_next_state[IDX_RUN]) begin
                r_fill <= {2'b00, i_dut_delay[15:0]} + FILL_ADD;
            end else if (r_state[IDX_RUN] && (r_fill != '0)) begin
                r_fill <= r_fill - {{(FILL_W-1){1'b0}}, 1'b1};
            end else begin
                r_fill <= r_fill;
            end
        end
    end

    // first-failure capture; later failures leave it untouched
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            r_fail_seen <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
        end else if (w_start_acc) begin
            r_fail_seen <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
        end else if (w_fail_inc && !r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_first_a   <= i_mon_a;
            r_first_b   <= i_mon_b;
        end else begin
            r_fail_seen <= r_fail_seen;
            r_first_a   <= r_first_a;
            r_first_b   <= r_first_b;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk_dut (clk_dut),
        .reset   (reset),
        .i_clr   (w_start_acc),
        .i_inc   (w_pass_inc),
        .o_count (w_pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk_dut (clk_dut),
        .reset   (reset),
        .i_clr   (w_start_acc),
        .i_inc   (w_fail_inc),
        .o_count (w_fail_cnt)
    );

    // Only combinational path to an output: the driver must see manual mode at once
    assign o_fselect      = r_state[IDX_IDLE] & i_manual;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_timeout      = r_timeout;
    assign o_pass_count   = w_pass_cnt;
    assign o_fail_count   = w_fail_cnt;
    assign o_fail_seen    = r_fail_seen;
    assign o_first_fail_a = r_first_a;
    assign o_first_fail_b = r_first_b;

endmodule
